// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers
// for the ALU issue controller.
package alu_pkg;

   localparam logic [3:0] OP_HOLD = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIV  = 4'b0101;
   localparam logic [3:0] OP_AND  = 4'b0110;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_NEG  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_ROL  = 4'b1110;
   localparam logic [3:0] OP_ROR  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
         OP_NEG, OP_NOT, OP_SHL, OP_SHR, OP_ROL, OP_ROR: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

   // Only multiply and divide produce a meaningful upper half in Z.
   function automatic logic writes_hilo(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter timing the ALU result latency; o_done marks the
// cycle in which the result is valid at the next edge.
module alu_lat_counter (
   input  logic       clk,
   input  logic       clr,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   output logic       o_done
);

   logic [3:0] r_count;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != 4'd0) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign o_done = (r_count == 4'd1);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU interface: issues one op with a single-cycle
// select pulse, waits out the op latency, captures Z/carry, returns result.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 1,
   parameter int unsigned DIV_LAT = 1,
   parameter int unsigned OP_LAT  = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [3:0]  alu_select,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [63:0] alu_z,
   input  logic        alu_carry,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_lo,
   output logic [31:0] res_hi,
   output logic        res_carry,
   output logic        res_err,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q,
   output logic        busy
);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_op;
   logic [3:0]  r_alu_select;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [31:0] r_res_lo;
   logic [31:0] r_res_hi;
   logic        r_res_carry;
   logic        r_res_err;
   logic [31:0] r_hi_q;
   logic [31:0] r_lo_q;
   logic [3:0]  w_lat;
   logic        w_load;
   logic        w_done;
   logic        w_req_ready;
   logic        w_res_valid;
   logic        w_busy;

   always_comb begin
      w_lat = 4'(OP_LAT);
      if (r_op == OP_MUL) begin
         w_lat = 4'(MUL_LAT);
      end else if (r_op == OP_DIV) begin
         w_lat = 4'(DIV_LAT);
      end
   end

   assign w_load = (r_state == ST_ISSUE);

   alu_lat_counter u_lat (
      .clk        (clk),
      .clr        (clr),
      .i_load     (w_load),
      .i_load_val (w_lat),
      .o_done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (req_valid) w_next = is_legal_op(req_op) ? ST_ISSUE : ST_RESP;
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT:  if (w_done) w_next = ST_RESP;
         ST_RESP:  if (res_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready = (r_state == ST_IDLE);
      w_res_valid = (r_state == ST_RESP);
      w_busy      = (r_state != ST_IDLE);
   end

   // Select is registered so the ALU sees the op only during ISSUE;
   // operands stay put through WAIT for a multi-cycle ALU.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_op         <= OP_HOLD;
         r_alu_select <= OP_HOLD;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_res_lo     <= '0;
         r_res_hi     <= '0;
         r_res_carry  <= 1'b0;
         r_res_err    <= 1'b0;
         r_hi_q       <= '0;
         r_lo_q       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (is_legal_op(req_op)) begin
                     r_op         <= req_op;
                     r_alu_select <= req_op;
                     r_alu_a      <= req_a;
                     r_alu_b      <= req_b;
                  end else begin
                     r_res_lo    <= '0;
                     r_res_hi    <= '0;
                     r_res_carry <= 1'b0;
                     r_res_err   <= 1'b1;
                  end
               end
            end
            ST_ISSUE: r_alu_select <= OP_HOLD;
            ST_WAIT: begin
               if (w_done) begin
                  r_res_lo    <= alu_z[31:0];
                  r_res_hi    <= writes_hilo(r_op) ? alu_z[63:32] : '0;
                  r_res_carry <= alu_carry;
                  r_res_err   <= 1'b0;
                  if (writes_hilo(r_op)) begin
                     r_hi_q <= alu_z[63:32];
                     r_lo_q <= alu_z[31:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = w_req_ready;
   assign res_valid  = w_res_valid;
   assign busy       = w_busy;
   assign alu_select = r_alu_select;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign res_lo     = r_res_lo;
   assign res_hi     = r_res_hi;
   assign res_carry  = r_res_carry;
   assign res_err    = r_res_err;
   assign hi_q       = r_hi_q;
   assign lo_q       = r_lo_q;

endmodule
